// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Up/down BCD counter with programmable modulus, synchronous
//               clear, validated parallel load and cascade carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_data,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic                borrow,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  // Converts a binary constant into its BCD image (digit 0 in the low nibble).
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] res;
    int unsigned  t;
    res = '0;
    t   = v;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(t % 10);
      t             = t / 10;
    end
    return res;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(32'(MODULUS - 1));

  logic [W-1:0] count_q, count_d;
  logic         load_err_q, load_err_d;
  logic [W-1:0] inc_val, dec_val;
  logic [31:0]  load_val;
  logic         digits_ok, load_ok;
  logic         is_max, is_zero;

  assign is_max  = (count_q == MAX_BCD);
  assign is_zero = (count_q == '0);

  // Decode the load word and decide whether it is a legal count value.
  always_comb begin
    load_val  = '0;
    digits_ok = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      load_val = load_val * 32'd10 + {28'd0, load_data[4*i +: 4]};
      if (load_data[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (load_val < 32'(MODULUS));
  end

  // Ripple BCD increment and decrement of the current count, digit by digit.
  always_comb begin
    logic cy;
    logic bw;
    inc_val = count_q;
    dec_val = count_q;
    cy      = 1'b1;
    bw      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cy) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          cy                = 1'b0;
        end
      end
      if (bw) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          bw                = 1'b0;
        end
      end
    end
  end

  // Next-state selection: clr > load > en; reset is applied in the register.
  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d = load_data;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (up) count_d = is_max  ? '0      : inc_val;
      else    count_d = is_zero ? MAX_BCD : dec_val;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  // Wrap indications are only meaningful when a plain count step will occur.
  assign carry    = en &  up & is_max  & ~clr & ~load & ~rst;
  assign borrow   = en & ~up & is_zero & ~clr & ~load & ~rst;
  assign count    = count_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_mod_counter
// Description : Scoreboard bench for bcd_mod_counter in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_mod_counter;

  logic clk;

  // DUT 0: DIGITS=2, MODULUS=60
  logic        rst0, clr0, load0, en0, up0;
  logic [7:0]  ld0, cnt0;
  logic        cy0, bw0, er0;
  // DUT 1: DIGITS=2, MODULUS=24
  logic        rst1, clr1, load1, en1, up1;
  logic [7:0]  ld1, cnt1;
  logic        cy1, bw1, er1;
  // DUT 2: DIGITS=3, MODULUS=1000
  logic        rst2, clr2, load2, en2, up2;
  logic [11:0] ld2, cnt2;
  logic        cy2, bw2, er2;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_dut0 (
    .clk(clk), .rst(rst0), .clr(clr0), .load(load0), .load_data(ld0),
    .en(en0), .up(up0), .count(cnt0), .carry(cy0), .borrow(bw0), .load_err(er0));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_dut1 (
    .clk(clk), .rst(rst1), .clr(clr1), .load(load1), .load_data(ld1),
    .en(en1), .up(up1), .count(cnt1), .carry(cy1), .borrow(bw1), .load_err(er1));
  bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) u_dut2 (
    .clk(clk), .rst(rst2), .clr(clr2), .load(load2), .load_data(ld2),
    .en(en2), .up(up2), .count(cnt2), .carry(cy2), .borrow(bw2), .load_err(er2));

  typedef struct {
    int          step;
    int          dut;
    logic [11:0] cnt;
    logic        cy;
    logic        bw;
    logic        er;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int st, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", st, name, act, exp);
    end
  endtask

  task automatic idle_all();
    rst0 = 0; clr0 = 0; load0 = 0; en0 = 0; up0 = 0; ld0 = '0;
    rst1 = 0; clr1 = 0; load1 = 0; en1 = 0; up1 = 0; ld1 = '0;
    rst2 = 0; clr2 = 0; load2 = 0; en2 = 0; up2 = 0; ld2 = '0;
  endtask

  // Drive one cycle of stimulus on DUT d and queue the expected response:
  // carry/borrow for this cycle, count/load_err after the coming edge.
  task automatic step(input int d, input logic r, input logic c, input logic l,
                      input logic [11:0] ld, input logic e, input logic u,
                      input logic [11:0] xc, input logic xcy, input logic xbw, input logic xer);
    item_t it;
    @(negedge clk);
    idle_all();
    case (d)
      0: begin rst0 = r; clr0 = c; load0 = l; ld0 = ld[7:0]; en0 = e; up0 = u; end
      1: begin rst1 = r; clr1 = c; load1 = l; ld1 = ld[7:0]; en1 = e; up1 = u; end
      default: begin rst2 = r; clr2 = c; load2 = l; ld2 = ld; en2 = e; up2 = u; end
    endcase
    it.step = step_no; it.dut = d; it.cnt = xc; it.cy = xcy; it.bw = xbw; it.er = xer;
    q.push_back(it);
    step_no++;
  endtask

  // Monitor: pops one expectation per cycle and compares against the DUT.
  initial begin
    item_t it;
    logic [11:0] a_cnt;
    logic a_cy, a_bw, a_er;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        it = q.pop_front();
        case (it.dut)
          0: begin a_cy = cy0; a_bw = bw0; end
          1: begin a_cy = cy1; a_bw = bw1; end
          default: begin a_cy = cy2; a_bw = bw2; end
        endcase
        chk("carry", it.step, {11'd0, a_cy}, {11'd0, it.cy});
        chk("borrow", it.step, {11'd0, a_bw}, {11'd0, it.bw});
        @(posedge clk);
        #1;
        case (it.dut)
          0: begin a_cnt = {4'd0, cnt0}; a_er = er0; end
          1: begin a_cnt = {4'd0, cnt1}; a_er = er1; end
          default: begin a_cnt = cnt2; a_er = er2; end
        endcase
        chk("count", it.step, a_cnt, it.cnt);
        chk("load_err", it.step, {11'd0, a_er}, {11'd0, it.er});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Directed vectors: step(dut, rst, clr, load, load_data, en, up, count, carry, borrow, load_err)
  initial begin
    idle_all();
    rst0 = 1; rst1 = 1; rst2 = 1;
    // ---- DUT 0, modulus 60 ----
    step(0, 1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0);  // reset
    step(0, 0, 0, 1, 12'h058, 0, 0, 12'h058, 0, 0, 0);  // load 58
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h059, 0, 0, 0);
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h000, 1, 0, 0);  // wrap up, carry
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h001, 0, 0, 0);
    step(0, 0, 1, 0, 12'h000, 1, 0, 12'h000, 0, 0, 0);  // clr
    step(0, 0, 1, 0, 12'h000, 1, 0, 12'h000, 0, 0, 0);  // clr at 0: no borrow
    step(0, 0, 0, 0, 12'h000, 1, 0, 12'h059, 0, 1, 0);  // wrap down, borrow
    step(0, 0, 0, 0, 12'h000, 1, 0, 12'h058, 0, 0, 0);
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h059, 0, 0, 0);  // direction change
    step(0, 0, 0, 0, 12'h000, 1, 0, 12'h058, 0, 0, 0);
    step(0, 0, 0, 1, 12'h06A, 1, 1, 12'h058, 0, 0, 1);  // bad digit
    step(0, 0, 0, 1, 12'h060, 1, 1, 12'h058, 0, 0, 1);  // out of range
    step(0, 0, 0, 0, 12'h000, 0, 0, 12'h058, 0, 0, 0);  // hold, err clears
    step(0, 0, 0, 1, 12'h045, 1, 1, 12'h045, 0, 0, 0);
    step(0, 0, 0, 0, 12'h000, 0, 1, 12'h045, 0, 0, 0);
    step(0, 0, 0, 1, 12'h059, 0, 0, 12'h059, 0, 0, 0);
    step(0, 0, 0, 0, 12'h000, 0, 1, 12'h059, 0, 0, 0);  // en=0 at max: no carry
    step(0, 0, 0, 1, 12'h012, 1, 1, 12'h012, 0, 0, 0);  // load beats carry
    step(0, 0, 0, 1, 12'h059, 0, 0, 12'h059, 0, 0, 0);
    step(0, 0, 1, 0, 12'h000, 1, 1, 12'h000, 0, 0, 0);  // clr beats carry
    step(0, 0, 0, 1, 12'h030, 1, 0, 12'h030, 0, 0, 0);  // load beats borrow
    step(0, 0, 0, 1, 12'h037, 0, 0, 12'h037, 0, 0, 0);
    step(0, 1, 0, 1, 12'h045, 1, 1, 12'h000, 0, 0, 0);  // rst overrides load
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h001, 0, 0, 0);
    step(0, 0, 0, 1, 12'h099, 1, 1, 12'h001, 0, 0, 1);  // invalid load
    step(0, 1, 0, 0, 12'h000, 1, 1, 12'h000, 0, 0, 0);  // rst clears err
    step(0, 0, 0, 0, 12'h000, 1, 1, 12'h001, 0, 0, 0);
    // ---- DUT 1, modulus 24 ----
    step(1, 0, 0, 1, 12'h022, 0, 0, 12'h022, 0, 0, 0);
    step(1, 0, 0, 0, 12'h000, 1, 1, 12'h023, 0, 0, 0);
    step(1, 0, 0, 0, 12'h000, 1, 1, 12'h000, 1, 0, 0);
    step(1, 0, 0, 0, 12'h000, 1, 1, 12'h001, 0, 0, 0);
    step(1, 0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 0);
    step(1, 0, 0, 0, 12'h000, 1, 0, 12'h023, 0, 1, 0);
    step(1, 0, 0, 1, 12'h024, 0, 0, 12'h023, 0, 0, 1);
    // ---- DUT 2, three digits, modulus 1000 ----
    step(2, 0, 0, 0, 12'h000, 1, 0, 12'h999, 0, 1, 0);
    step(2, 0, 0, 0, 12'h000, 1, 1, 12'h000, 1, 0, 0);
    step(2, 0, 0, 1, 12'h9A9, 1, 1, 12'h000, 0, 0, 1);
    step(2, 0, 0, 1, 12'h099, 0, 0, 12'h099, 0, 0, 0);
    step(2, 0, 0, 0, 12'h000, 1, 1, 12'h100, 0, 0, 0);
    step(2, 0, 0, 0, 12'h000, 1, 0, 12'h099, 0, 0, 0);
    @(negedge clk);
    idle_all();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits in the count.
REQ-002 Parameter MODULUS, default 60: count range is 0 to MODULUS-1; the supported range is 2 <= MODULUS <= 10^DIGITS.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clr  input  1  synchronous clear of the count to zero.
REQ-006 load  input  1  synchronous parallel load request.
REQ-007 load_data  input  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
REQ-008 en  input  1  count enable; one step per enabled cycle.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 count  output  4*DIGITS  registered BCD count; digit 0 is in bits [3:0].
REQ-011 carry  output  1  combinational wrap-up indication for cascading.
REQ-012 borrow  output  1  combinational wrap-down indication for cascading.
REQ-013 load_err  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-014 Per-edge priority SHALL be rst > clr > load > en; lower-priority requests in the same cycle are ignored.
REQ-015 Each digit of count SHALL always hold a value 0-9, and the full count SHALL always be in 0..MODULUS-1.
REQ-016 With en=1 and up=1, count SHALL increment by one in BCD on the next edge: a digit at 9 goes to 0 and the next digit increments.
REQ-017 With en=1, up=1 and count=MODULUS-1, count SHALL become 0 on the next edge.
REQ-018 With en=1 and up=0, count SHALL decrement by one in BCD on the next edge: a digit at 0 goes to 9 and the next digit decrements.
REQ-019 With en=1, up=0 and count=0, count SHALL become MODULUS-1, BCD-encoded, on the next edge.
REQ-020 With en=0 and no clr or load, count SHALL hold.
REQ-021 carry SHALL equal en & up & (count==MODULUS-1) & ~clr & ~load & ~rst, with zero-cycle latency.
REQ-022 borrow SHALL equal en & ~up & (count==0) & ~clr & ~load & ~rst, with zero-cycle latency.
REQ-023 A load SHALL be valid when every load_data digit is <= 9 and the decoded value is < MODULUS.
REQ-024 On a valid load, count SHALL equal load_data on the next edge and load_err SHALL be 0.
REQ-025 On an invalid load, count SHALL hold, load_err SHALL be 1 for exactly the next cycle, and en SHALL be ignored that cycle.
REQ-026 load_err SHALL be 0 in every cycle not immediately following an invalid load.
REQ-027 clr SHALL force count to 0 on the next edge regardless of en, up and load, and SHALL assert neither carry nor borrow.
REQ-028 Changing up between cycles SHALL take effect on the very next enabled edge, with no dead cycle.
REQ-029 Counters SHALL cascade: feeding a lower stage's carry|borrow into a higher stage's en, with a shared up, SHALL form a correct multi-stage counter.

Reset
REQ-030 While rst=1 at an edge, count SHALL become 0 and load_err SHALL become 0.
REQ-031 rst asserted mid-count or mid-load SHALL override all other inputs on that edge.
REQ-032 carry and borrow SHALL be 0 in any cycle where rst=1.

Verification (DIGITS=2, MODULUS=60 unless stated)
REQ-033 Load 0x58, then en=1, up=1 for 3 cycles -> count 0x59, 0x00, 0x01; carry=1 only in the cycle count=0x59.
REQ-034 count=0x00, en=1, up=0 for 2 cycles -> count 0x59, then 0x58; borrow=1 only in the cycle count=0x00.
REQ-035 load_data=0x6A or 0x60 with load=1 and en=1 -> count unchanged and load_err=1 for one cycle; load_data=0x45 -> count 0x45 and load_err=0.
REQ-036 count=0x59 with load=1 (0x12), en=1, up=1 -> carry=0 and next count=0x12; clr=1 in the same cycle instead -> count 0x00.
REQ-037 rst=1 while counting at 0x37 with load asserted -> next count 0x00 and load_err=0; counting resumes from 0x00 after rst drops.
REQ-038 DIGITS=2, MODULUS=24, up count from 0x22 -> 0x23, 0x00 with carry at 0x23; DIGITS=3, MODULUS=1000, down from 0x000 -> 0x999.
